ll_display: RTL and testbench

Display stage of the lunar lander, directly downstream of `ll_memory` and `ll_control`. It takes the four BCD lander quantities and the land/crash flags and drives the seven-segment displays and RGB status LEDs. A quantity is selected with the Z/Y/X/W pushbuttons, taken from `keysync`. Negative values are shown as sign plus magnitude with leading-zero blanking, and the display blinks once the flight has ended.

---
 rtl/ll_pkg.sv | 45 ++++
 rtl/bcdaddsub4.sv | 31 +++
 rtl/ll_bcdabs.sv | 23 ++
 rtl/ssdec.sv | 29 ++
 rtl/ll_display.sv | 145 ++++++++++++++
 tb/tb_ll_display.sv | 241 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar lander display stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ll_pkg;

    typedef enum logic [1:0] {
        SEL_ALT    = 2'd0,
        SEL_VEL    = 2'd1,
        SEL_FUEL   = 2'd2,
        SEL_THRUST = 2'd3
    } sel_t;

    typedef enum logic [1:0] {
        FL_FLYING  = 2'd0,
        FL_LANDED  = 2'd1,
        FL_CRASHED = 2'd2
    } flight_t;

    localparam logic [4:0] KEY_W = 5'd16;
    localparam logic [4:0] KEY_X = 5'd17;
    localparam logic [4:0] KEY_Y = 5'd18;
    localparam logic [4:0] KEY_Z = 5'd19;

    localparam logic [7:0] GLYPH_ALT    = 8'h77;
    localparam logic [7:0] GLYPH_VEL    = 8'h3E;
    localparam logic [7:0] GLYPH_FUEL   = 8'h71;
    localparam logic [7:0] GLYPH_THRUST = 8'h78;
    localparam logic [7:0] GLYPH_MINUS  = 8'h40;

    localparam logic [3:0] NEG_THRESH = 4'h5;

    function automatic logic [7:0] label_glyph(input sel_t s);
        logic [7:0] g;
        g = GLYPH_ALT;
        case (s)
            SEL_ALT:    g = GLYPH_ALT;
            SEL_VEL:    g = GLYPH_VEL;
            SEL_FUEL:   g = GLYPH_FUEL;
            SEL_THRUST: g = GLYPH_THRUST;
            default:    g = GLYPH_ALT;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcdaddsub4.sv
// 4-digit BCD adder/subtractor: s = a + b (op=0) or a - b (op=1), carry dropped.
// Latency: combinational.
// Backpressure: n/a.
module bcdaddsub4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        op,
    output logic [15:0] s
);
    always_comb begin
        logic       c;
        logic [3:0] bd;
        logic [4:0] t;
        c  = op;
        bd = '0;
        t  = '0;
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            // Nine's complement of each digit plus the initial carry gives ten's complement.
            bd = op ? (4'd9 - b[i*4 +: 4]) : b[i*4 +: 4];
            t  = {1'b0, a[i*4 +: 4]} + {1'b0, bd} + {4'b0, c};
            if (t > 5'd9) begin
                t = t + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[i*4 +: 4] = t[3:0];
        end
    end
endmodule

// File: rtl/ll_bcdabs.sv
// Splits a ten's-complement BCD value into sign and magnitude.
// Latency: combinational.
// Backpressure: n/a.
module ll_bcdabs
    import ll_pkg::*;
(
    input  logic [15:0] val,
    output logic        neg,
    output logic [15:0] mag
);
    logic [15:0] diff;

    bcdaddsub4 u_sub (
        .a  (16'h0000),
        .b  (val),
        .op (1'b1),
        .s  (diff)
    );

    // 5000 negates to itself, so it still shows as -5000.
    assign neg = (val[15:12] >= NEG_THRESH);
    assign mag = neg ? diff : val;
endmodule

// File: rtl/ssdec.sv
// Hex nibble to seven-segment glyph (gfedcba, decimal point always off).
// Latency: combinational.
// Backpressure: n/a.
module ssdec (
    input  logic [3:0] in,
    output logic [7:0] out
);
    always_comb begin
        out = 8'h00;
        case (in)
            4'h0: out = 8'h3F;
            4'h1: out = 8'h06;
            4'h2: out = 8'h5B;
            4'h3: out = 8'h4F;
            4'h4: out = 8'h66;
            4'h5: out = 8'h6D;
            4'h6: out = 8'h7D;
            4'h7: out = 8'h07;
            4'h8: out = 8'h7F;
            4'h9: out = 8'h6F;
            4'hA: out = 8'h77;
            4'hB: out = 8'h7C;
            4'hC: out = 8'h39;
            4'hD: out = 8'h5E;
            4'hE: out = 8'h79;
            4'hF: out = 8'h71;
        endcase
    end
endmodule

// File: rtl/ll_display.sv
// Lander display: key-selected quantity on seven-segment digits plus flight status LEDs.
// Latency: one registered stage; key or flag takes effect at its edge, display one edge later.
// Backpressure: none; free-running, every input sampled each cycle.
module ll_display
    import ll_pkg::*;
#(
    parameter int BLINK_HALF = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  keyout,
    input  logic        keyclk,
    input  logic [15:0] alt,
    input  logic [15:0] vel,
    input  logic [15:0] fuel,
    input  logic [15:0] thrust,
    input  logic        land,
    input  logic        crash,
    output logic [7:0]  ss7,
    output logic [7:0]  ss6,
    output logic [7:0]  ss5,
    output logic [7:0]  ss4,
    output logic [7:0]  ss3,
    output logic [7:0]  ss2,
    output logic [7:0]  ss1,
    output logic [7:0]  ss0,
    output logic        red,
    output logic        green,
    output logic        blue
);
    localparam int CW = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [CW-1:0] HALF_C = CW'(BLINK_HALF);
    localparam logic [CW-1:0] LAST_C = CW'(2 * BLINK_HALF - 1);

    sel_t            sel_q, sel_d;
    flight_t         flight_q, flight_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            keyclk_q, keyclk_d;
    logic [7:0][7:0] seg_q, seg_d;
    logic            red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic [15:0]     val;
    logic            neg;
    logic [15:0]     mag;
    logic [3:0][7:0] glyph;
    logic            blank;

    ll_bcdabs u_abs (
        .val (val),
        .neg (neg),
        .mag (mag)
    );

    for (genvar g = 0; g < 4; g++) begin : g_dec
        ssdec u_dec (
            .in  (mag[g*4 +: 4]),
            .out (glyph[g])
        );
    end

    always_comb begin
        keyclk_d = keyclk;
        sel_d    = sel_q;
        if (keyclk && !keyclk_q) begin
            case (keyout)
                KEY_Z:   sel_d = SEL_ALT;
                KEY_Y:   sel_d = SEL_VEL;
                KEY_X:   sel_d = SEL_FUEL;
                KEY_W:   sel_d = SEL_THRUST;
                default: sel_d = sel_q;
            endcase
        end

        val = alt;
        case (sel_q)
            SEL_ALT:    val = alt;
            SEL_VEL:    val = vel;
            SEL_FUEL:   val = fuel;
            SEL_THRUST: val = thrust;
            default:    val = alt;
        endcase

        flight_d = flight_q;
        if (flight_q == FL_FLYING) begin
            if (crash)     flight_d = FL_CRASHED;
            else if (land) flight_d = FL_LANDED;
        end

        // Counter idles at 0 while flying, so entering a terminal state starts a fresh period.
        cnt_d = '0;
        if (flight_q != FL_FLYING) begin
            cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + 1'b1;
        end
        blank = (flight_q != FL_FLYING) && (cnt_q >= HALF_C);

        seg_d    = '0;
        seg_d[7] = label_glyph(sel_q);
        seg_d[4] = neg ? GLYPH_MINUS : 8'h00;
        seg_d[3] = (mag[15:12] != 4'h0) ? glyph[3] : 8'h00;
        seg_d[2] = (mag[15:8]  != 8'h0) ? glyph[2] : 8'h00;
        seg_d[1] = (mag[15:4]  != 12'h0) ? glyph[1] : 8'h00;
        seg_d[0] = glyph[0];
        if (blank) begin
            seg_d[4:0] = '0;
        end

        red_d   = (flight_d == FL_CRASHED);
        green_d = (flight_d == FL_LANDED);
        blue_d  = (flight_d == FL_FLYING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= SEL_ALT;
            flight_q <= FL_FLYING;
            cnt_q    <= '0;
            keyclk_q <= 1'b0;
            seg_q    <= '0;
            red_q    <= 1'b0;
            green_q  <= 1'b0;
            blue_q   <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            flight_q <= flight_d;
            cnt_q    <= cnt_d;
            keyclk_q <= keyclk_d;
            seg_q    <= seg_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign ss7   = seg_q[7];
    assign ss6   = seg_q[6];
    assign ss5   = seg_q[5];
    assign ss4   = seg_q[4];
    assign ss3   = seg_q[3];
    assign ss2   = seg_q[2];
    assign ss1   = seg_q[1];
    assign ss0   = seg_q[0];
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
endmodule

// File: tb/tb_ll_display.sv
// Directed self-checking bench for ll_display; inputs driven and outputs sampled on the falling edge.
// Expected segment words are written as {ss7..ss0}, LEDs as {red,green,blue}.
// Backpressure: n/a.
module tb_ll_display;
    logic        clk;
    logic        rst_n;
    logic [4:0]  keyout;
    logic        keyclk;
    logic [15:0] alt, vel, fuel, thrust;
    logic        land, crash;
    logic [7:0]  ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0;
    logic        red, green, blue;

    int checks = 0;
    int errors = 0;

    ll_display #(.BLINK_HALF(25)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .keyout (keyout),
        .keyclk (keyclk),
        .alt    (alt),
        .vel    (vel),
        .fuel   (fuel),
        .thrust (thrust),
        .land   (land),
        .crash  (crash),
        .ss7    (ss7),
        .ss6    (ss6),
        .ss5    (ss5),
        .ss4    (ss4),
        .ss3    (ss3),
        .ss2    (ss2),
        .ss1    (ss1),
        .ss0    (ss0),
        .red    (red),
        .green  (green),
        .blue   (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] ALT4500   = 64'h77_00_00_00_66_6D_3F_3F;
    localparam logic [63:0] ALTBLANK  = 64'h77_00_00_00_00_00_00_00;
    localparam logic [63:0] VEL9970   = 64'h3E_00_00_40_00_00_4F_3F;
    localparam logic [63:0] VEL0000   = 64'h3E_00_00_00_00_00_00_3F;
    localparam logic [63:0] VEL5000   = 64'h3E_00_00_40_6D_3F_3F_3F;
    localparam logic [63:0] FUEL0042  = 64'h71_00_00_00_00_00_66_5B;
    localparam logic [63:0] THR0205   = 64'h78_00_00_00_00_5B_3F_6D;

    function automatic logic [63:0] segs();
        return {ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; keyout = 5'd0; keyclk = 1'b0;
        alt = 16'h4500; vel = 16'h0000; fuel = 16'h0042; thrust = 16'h0205;
        land = 1'b0; crash = 1'b0;
        cyc(3);
        checks++;
        if (segs() !== 64'h0) begin
            errors++; $display("FAIL reset_segs got %h want %h", segs(), 64'h0);
        end
        checks++;
        if ({red, green, blue} !== 3'b000) begin
            errors++; $display("FAIL reset_leds got %b want 000", {red, green, blue});
        end
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if (segs() !== ALT4500) begin
            errors++; $display("FAIL alt_4500 got %h want %h", segs(), ALT4500);
        end
        checks++;
        if ({red, green, blue} !== 3'b001) begin
            errors++; $display("FAIL flying_leds got %b want 001", {red, green, blue});
        end
    endtask

    task automatic test_vel_negative();
        vel = 16'h9970; keyout = 5'd18; keyclk = 1'b1;
        cyc(1);
        keyclk = 1'b0;
        cyc(1);
        checks++;
        if (segs() !== VEL9970) begin
            errors++; $display("FAIL vel_9970 got %h want %h", segs(), VEL9970);
        end
    endtask

    task automatic test_zero_and_min();
        vel = 16'h0000;
        cyc(1);
        checks++;
        if (segs() !== VEL0000) begin
            errors++; $display("FAIL vel_0000 got %h want %h", segs(), VEL0000);
        end
        vel = 16'h5000;
        cyc(1);
        checks++;
        if (segs() !== VEL5000) begin
            errors++; $display("FAIL vel_5000 got %h want %h", segs(), VEL5000);
        end
    endtask

    task automatic test_bad_key();
        keyout = 5'd5; keyclk = 1'b1;
        cyc(1);
        keyclk = 1'b0;
        cyc(2);
        checks++;
        if (segs() !== VEL5000) begin
            errors++; $display("FAIL bad_key got %h want %h", segs(), VEL5000);
        end
    endtask

    task automatic test_held_key();
        keyout = 5'd17; keyclk = 1'b1;
        cyc(2);
        checks++;
        if (segs() !== FUEL0042) begin
            errors++; $display("FAIL held_key_fuel got %h want %h", segs(), FUEL0042);
        end
        // A code change while still held must not count as a new press.
        keyout = 5'd16;
        cyc(8);
        keyclk = 1'b0;
        cyc(2);
        checks++;
        if (segs() !== FUEL0042) begin
            errors++; $display("FAIL held_key_single got %h want %h", segs(), FUEL0042);
        end
    endtask

    task automatic test_thrust();
        keyout = 5'd16; keyclk = 1'b1;
        cyc(1);
        keyclk = 1'b0;
        cyc(1);
        checks++;
        if (segs() !== THR0205) begin
            errors++; $display("FAIL thrust_0205 got %h want %h", segs(), THR0205);
        end
        keyout = 5'd19; keyclk = 1'b1;
        cyc(1);
        keyclk = 1'b0;
        cyc(1);
        checks++;
        if (segs() !== ALT4500) begin
            errors++; $display("FAIL back_to_alt got %h want %h", segs(), ALT4500);
        end
    endtask

    task automatic test_crash_blink();
        logic [63:0] exp;
        crash = 1'b1; land = 1'b1;
        cyc(1);
        crash = 1'b0; land = 1'b0;
        // k counts falling edges since the edge that sampled crash.
        for (int k = 0; k < 80; k++) begin
            if (k > 0) cyc(1);
            exp = (k >= 1 && ((k - 1) % 50) >= 25) ? ALTBLANK : ALT4500;
            checks++;
            if (segs() !== exp) begin
                errors++; $display("FAIL blink k=%0d got %h want %h", k, segs(), exp);
            end
        end
        checks++;
        if ({red, green, blue} !== 3'b100) begin
            errors++; $display("FAIL crash_leds got %b want 100", {red, green, blue});
        end
    endtask

    task automatic test_reset_mid_blink();
        keyout = 5'd18; keyclk = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({segs(), red, green, blue} !== 67'h0) begin
            errors++; $display("FAIL async_reset got %h want 0", {segs(), red, green, blue});
        end
        cyc(2);
        keyclk = 1'b0;
        rst_n = 1'b1;
        cyc(1);
        checks++;
        if (segs() !== ALT4500) begin
            errors++; $display("FAIL post_reset_segs got %h want %h", segs(), ALT4500);
        end
        checks++;
        if ({red, green, blue} !== 3'b001) begin
            errors++; $display("FAIL post_reset_leds got %b want 001", {red, green, blue});
        end
    endtask

    task automatic test_land();
        land = 1'b1;
        cyc(1);
        land = 1'b0;
        checks++;
        if ({red, green, blue} !== 3'b010) begin
            errors++; $display("FAIL land_leds got %b want 010", {red, green, blue});
        end
        cyc(25);
        checks++;
        if (segs() !== ALT4500) begin
            errors++; $display("FAIL land_lit got %h want %h", segs(), ALT4500);
        end
        cyc(1);
        checks++;
        if (segs() !== ALTBLANK) begin
            errors++; $display("FAIL land_blank got %h want %h", segs(), ALTBLANK);
        end
        crash = 1'b1;
        cyc(1);
        crash = 1'b0;
        checks++;
        if ({red, green, blue} !== 3'b010) begin
            errors++; $display("FAIL land_terminal got %b want 010", {red, green, blue});
        end
    endtask

    initial begin
        test_reset();
        test_vel_negative();
        test_zero_and_min();
        test_bad_key();
        test_held_key();
        test_thrust();
        test_crash_blink();
        test_reset_mid_blink();
        test_land();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
